// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bundle between the multicycle control FSM and the datapath.
// slave = the FSM (consumes instruction fields, drives controls),
// master = the datapath/IR side.
interface multicycle_ctrl_fsm_if #(
  parameter int STATE_W = 4
);
  logic               Stall;
  logic [1:0]         Op;
  logic [5:0]         Funct;
  logic               IRWrite;
  logic               AdrSrc;
  logic [1:0]         ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [1:0]         ResultSrc;
  logic               ALUOp;
  logic               NextPC;
  logic               RegW;
  logic               MemW;
  logic               Branch;
  logic [STATE_W-1:0] State;

  modport master (
    output Stall, Op, Funct,
    input  IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp,
           NextPC, RegW, MemW, Branch, State
  );

  modport slave (
    input  Stall, Op, Funct,
    output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp,
           NextPC, RegW, MemW, Branch, State
  );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multicycle ARM datapath.
// Sequences FETCH/DECODE/execute/memory/writeback and emits raw (not
// condition-gated) strobes plus datapath mux selects. Outputs are Moore,
// held in registers alongside the state; strobes are forced low
// combinationally while reset or Stall is high.
// Optional macro CTRL_ILLEGAL_TRAP_EN: Op=11 in DECODE enters a TRAP
// state that holds until reset and raises Fault.
module multicycle_ctrl_fsm #(
  parameter int STATE_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  multicycle_ctrl_fsm_if.slave  io
`ifdef CTRL_ILLEGAL_TRAP_EN
  ,
  output logic                  Fault
`endif
);

  typedef enum logic [STATE_W-1:0] {
    FETCH    = STATE_W'(0),
    DECODE   = STATE_W'(1),
    MEMADR   = STATE_W'(2),
    MEMREAD  = STATE_W'(3),
    MEMWB    = STATE_W'(4),
    MEMWRITE = STATE_W'(5),
    EXECUTER = STATE_W'(6),
    EXECUTEI = STATE_W'(7),
    ALUWB    = STATE_W'(8),
    BRANCH   = STATE_W'(9)
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    TRAP     = STATE_W'(10)
`endif
  } state_t;

  typedef struct packed {
    logic       ir_write;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       alu_op;
    logic       next_pc;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic       fault;
`endif
  } ctrl_t;

  state_t state_q;
  ctrl_t  ctrl_q;
  logic   gate;
  logic   unused_funct_bits;

  // Successor state; Op/Funct only matter in DECODE and MEMADR.
  function automatic state_t next_state(input state_t s, input logic [1:0] op,
                                        input logic funct5, input logic funct0);
    unique case (s)
      FETCH:    next_state = DECODE;
      DECODE: begin
        unique case (op)
          2'b00:   next_state = funct5 ? EXECUTEI : EXECUTER;
          2'b01:   next_state = MEMADR;
          2'b10:   next_state = BRANCH;
`ifdef CTRL_ILLEGAL_TRAP_EN
          default: next_state = TRAP;
`else
          default: next_state = FETCH;
`endif
        endcase
      end
      MEMADR:   next_state = funct0 ? MEMREAD : MEMWRITE;
      MEMREAD:  next_state = MEMWB;
      EXECUTER,
      EXECUTEI: next_state = ALUWB;
`ifdef CTRL_ILLEGAL_TRAP_EN
      TRAP:     next_state = TRAP;
`endif
      default:  next_state = FETCH;
    endcase
  endfunction

  // Moore output table for one state.
  function automatic ctrl_t decode(input state_t s);
    // NOTE: zero every field before the case so no path leaves a field unassigned.
    decode = '0;
    unique case (s)
      FETCH: begin
        decode.alu_src_a  = 2'b01;
        decode.alu_src_b  = 2'b10;
        decode.result_src = 2'b10;
        decode.ir_write   = 1'b1;
        decode.next_pc    = 1'b1;
      end
      DECODE: begin
        decode.alu_src_a  = 2'b01;
        decode.alu_src_b  = 2'b10;
        decode.result_src = 2'b10;
      end
      MEMADR:   decode.alu_src_b = 2'b01;
      MEMREAD:  decode.adr_src   = 1'b1;
      MEMWB: begin
        decode.result_src = 2'b01;
        decode.reg_w      = 1'b1;
      end
      MEMWRITE: begin
        decode.adr_src = 1'b1;
        decode.mem_w   = 1'b1;
      end
      EXECUTER: decode.alu_op = 1'b1;
      EXECUTEI: begin
        decode.alu_src_b = 2'b01;
        decode.alu_op    = 1'b1;
      end
      ALUWB:    decode.reg_w = 1'b1;
      BRANCH: begin
        decode.alu_src_b  = 2'b01;
        decode.result_src = 2'b10;
        decode.branch     = 1'b1;
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      TRAP:     decode.fault = 1'b1;
`endif
      default:  decode = '0;
    endcase
  endfunction

  // State register with its registered Moore outputs; both freeze on Stall.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking so state and outputs all update from pre-edge values.
    if (reset) begin
      state_q <= FETCH;
      ctrl_q  <= decode(FETCH);
    end else if (!io.Stall) begin
      state_q <= next_state(state_q, io.Op, io.Funct[5], io.Funct[0]);
      ctrl_q  <= decode(next_state(state_q, io.Op, io.Funct[5], io.Funct[0]));
    end
  end

  // Write strobes are suppressed while reset or Stall is asserted.
  assign gate = reset | io.Stall;

  assign io.IRWrite   = ctrl_q.ir_write & ~gate;
  assign io.NextPC    = ctrl_q.next_pc  & ~gate;
  assign io.RegW      = ctrl_q.reg_w    & ~gate;
  assign io.MemW      = ctrl_q.mem_w    & ~gate;
  assign io.Branch    = ctrl_q.branch   & ~gate;
  assign io.AdrSrc    = ctrl_q.adr_src;
  assign io.ALUSrcA   = ctrl_q.alu_src_a;
  assign io.ALUSrcB   = ctrl_q.alu_src_b;
  assign io.ResultSrc = ctrl_q.result_src;
  assign io.ALUOp     = ctrl_q.alu_op;
  assign io.State     = state_q;

`ifdef CTRL_ILLEGAL_TRAP_EN
  assign Fault = ctrl_q.fault;
`endif

  // Funct[4:1] belong to the ALU decoder, not to sequencing.
  assign unused_funct_bits = ^io.Funct[4:1];

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm. A reference model maps each
// instruction to its FETCH-to-FETCH state path and each state to its output
// table; random instructions, random stalls and garbage Op/Funct outside
// DECODE/MEMADR are applied. Build with +define+CTRL_ILLEGAL_TRAP_EN to
// cover the TRAP feature.
module tb_multicycle_ctrl_fsm;
  localparam int STATE_W = 4;

  logic clk = 1'b0;
  logic reset;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic fault;
`endif
  int vectors     = 0;
  int miscompares = 0;

  multicycle_ctrl_fsm_if #(.STATE_W(STATE_W)) io ();

  multicycle_ctrl_fsm #(.STATE_W(STATE_W)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    .Fault (fault)
`endif
  );

  always #5 clk = ~clk;

  // Output table, packed {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
  // ALUOp, NextPC, RegW, MemW, Branch}.
  function automatic logic [12:0] spec_outputs(input int s);
    case (s)
      0: return {1'b1, 1'b0, 2'b01, 2'b10, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      1: return {1'b0, 1'b0, 2'b01, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      2: return {1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      3: return {1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      4: return {1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      5: return {1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      6: return {1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      7: return {1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      8: return {1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      9: return {1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      default: return 13'd0;
    endcase
  endfunction

  // Whole-instruction path, FETCH through the last state before FETCH.
  task automatic build_path(input logic [1:0] op, input logic [5:0] funct,
                            output int path[$]);
    path = {0, 1};
    case (op)
      2'b00: path = {path, (funct[5] ? 7 : 6), 8};
      2'b01: path = funct[0] ? {path, 2, 3, 4} : {path, 2, 5};
      2'b10: path = {path, 9};
      default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
        path = {path, 10};
`endif
      end
    endcase
  endtask

  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called #1 after an edge; checks at the next negedge, returns #1 after
  // the following posedge.
  task automatic cycle_check(input int s);
    logic [12:0] exp_v;
    logic [12:0] obs_v;
    logic [3:0]  strobes;
    @(negedge clk);
    exp_v = spec_outputs(s);
    if (reset || io.Stall) begin
      exp_v[12]  = 1'b0;
      exp_v[3:0] = 4'b0000;
    end
    strobes = {io.NextPC, io.RegW, io.MemW, io.Branch};
    obs_v   = {io.IRWrite, io.AdrSrc, io.ALUSrcA, io.ALUSrcB, io.ResultSrc,
               io.ALUOp, strobes};
    check("state", 16'(io.State), 16'(s));
    check("outputs", {3'b000, obs_v}, {3'b000, exp_v});
    check("strobe_onehot", 16'($countones(strobes) <= 1), 16'd1);
`ifdef CTRL_ILLEGAL_TRAP_EN
    check("fault", 16'(fault), 16'(s == 10));
`endif
    @(posedge clk);
    #1;
  endtask

  // One instruction; stall_len stall cycles are inserted on path[stall_pos].
  task automatic run_instr(input logic [1:0] op, input logic [5:0] funct,
                           input int stall_pos, input int stall_len);
    int path[$];
    build_path(op, funct, path);
    foreach (path[i]) begin
      if (path[i] == 1 || path[i] == 2) begin
        io.Op    = op;
        io.Funct = funct;
      end else begin
        io.Op    = 2'($urandom);
        io.Funct = 6'($urandom);
      end
      if (i == stall_pos) begin
        repeat (stall_len) begin
          io.Stall = 1'b1;
          cycle_check(path[i]);
        end
      end
      io.Stall = 1'b0;
      cycle_check(path[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] op;
    reset    = 1'b1;
    io.Stall = 1'b0;
    io.Op    = 2'b00;
    io.Funct = 6'd0;
    @(posedge clk);
    #1;
    // Reset held two cycles; reset wins over Stall.
    io.Stall = 1'b1;
    cycle_check(0);
    io.Stall = 1'b0;
    cycle_check(0);
    reset = 1'b0;

    // Directed: LDR, STR, ADD imm, B.
    run_instr(2'b01, 6'b011001, -1, 0);
    run_instr(2'b01, 6'b011000, -1, 0);
    run_instr(2'b00, 6'b101000, -1, 0);
    run_instr(2'b10, 6'($urandom), -1, 0);
    // Data-processing register form.
    run_instr(2'b00, 6'b001000, -1, 0);
    // STR stalled 3 cycles in MEMWRITE.
    run_instr(2'b01, 6'b011000, 3, 3);
    // LDR stalled in DECODE and in MEMWB.
    run_instr(2'b01, 6'b011001, 1, 2);
    run_instr(2'b01, 6'b011001, 4, 1);

    // Illegal Op=11.
    run_instr(2'b11, 6'($urandom), -1, 0);
`ifdef CTRL_ILLEGAL_TRAP_EN
    repeat (20) begin
      io.Stall = 1'($urandom);
      io.Op    = 2'($urandom);
      io.Funct = 6'($urandom);
      cycle_check(10);
    end
    io.Stall = 1'b0;
    reset    = 1'b1;
    cycle_check(10);
    cycle_check(0);
    reset = 1'b0;
`endif
    run_instr(2'b10, 6'($urandom), 0, 2);

    // Random instructions with random stalls.
    for (int n = 0; n < 80; n++) begin
      op = 2'($urandom);
`ifdef CTRL_ILLEGAL_TRAP_EN
      if (op == 2'b11) op = 2'($urandom_range(0, 2));
`endif
      run_instr(op, 6'($urandom), $urandom_range(0, 6), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
